axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ID0, default 4'd0, the AXI arid driven for requester 0 (instruction fetch).
REQ-002 SHALL have parameter ID1, default 4'd1, the AXI arid driven for requester 1 (data).
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports m0_arvalid/m1_arvalid, input, 1 bit each: requester read request.
REQ-006 SHALL have ports m0_araddr/m1_araddr, input, 32 bits; m0_arlen/m1_arlen, input, 8 bits; m0_arsize/m1_arsize, input, 3 bits.
REQ-007 SHALL have ports m0_arready/m1_arready, output, 1 bit each: request accepted this cycle.
REQ-008 SHALL have ports m0_rvalid/m1_rvalid and m0_rlast/m1_rlast, output, 1 bit each; m0_rdata/m1_rdata, output, 32 bits; m0_rresp/m1_rresp, output, 2 bits.
REQ-009 SHALL have the AXI3 read master outputs arid (4), araddr (32), arlen (8), arsize (3), arburst (2), arlock (2), arcache (4), arprot (3), arvalid (1), rready (1).
REQ-010 SHALL have the AXI3 read master inputs arready (1), rid (4), rdata (32), rresp (2), rlast (1), rvalid (1).
REQ-011 SHALL have port rd_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-012 SHALL implement the FSM states IDLE, ADDR and DATA, with one outstanding burst at a time.
REQ-013 In IDLE with any mX_arvalid, the arbiter SHALL grant one requester, pulse its mX_arready for that cycle, latch addr/len/size/grant, and go to ADDR.
REQ-014 When both requesters are valid, the grant SHALL go to the requester not granted last; last_grant SHALL update at grant and reset to 1, so m0 wins the first tie.
REQ-015 mX_arready SHALL be 0 in ADDR and DATA, and SHALL never be 1 for both requesters in the same cycle.
REQ-016 In ADDR, arvalid SHALL be 1 with the latched araddr/arlen/arsize and arid = ID of the granted requester, all held stable until arready; arvalid first rises the cycle after the grant.
REQ-017 On arvalid&&arready the FSM SHALL go to DATA; arvalid SHALL be 0 outside ADDR.
REQ-018 arburst SHALL be 2'b01 (INCR), and arlock, arcache and arprot SHALL be 0, at all times.
REQ-019 In DATA, rready SHALL be 1; it SHALL be 0 in IDLE and ADDR.
REQ-020 In DATA, the granted mX_rvalid SHALL equal rvalid combinationally, with rdata/rresp/rlast passed through; the other requester's rvalid SHALL be 0. Requesters always accept.
REQ-021 An 8-bit beat counter SHALL clear on grant and increment on each rvalid&&rready.
REQ-022 On rvalid&&rlast in DATA, the FSM SHALL return to IDLE; a new grant is possible in the very next cycle (no bubble beyond IDLE).
REQ-023 rd_err SHALL set and stay set on: rid != granted ID during a beat; rlast on a beat where counter != latched len; or beat counter == len without rlast. Data SHALL still be forwarded, and only rlast ends the burst.
REQ-024 rvalid arriving in IDLE or ADDR SHALL be ignored: not forwarded, no error.

Reset
REQ-025 areset SHALL immediately force IDLE, with arvalid, rready, m0/m1_arready, m0/m1_rvalid and rd_err all 0, last_grant = 1, and latched registers and counter = 0.
REQ-026 Reset asserted mid-ADDR or mid-DATA SHALL abandon the burst without completing it; after release, normal arbitration SHALL resume from IDLE.

Verification
REQ-027 Single request: m0 req addr 0x1C000000, len 3, size 2 -> m0_arready at T; arvalid T+1 with arid 0, araddr 0x1C000000, arlen 3; 4 beats to m0 only; IDLE after rlast; rd_err 0.
REQ-028 Tie: m0 and m1 valid together, repeated 3 times -> grants m0, m1, m0; arid 0, 1, 0.
REQ-029 arready held low 5 cycles -> arvalid and all ar fields stable for 6 cycles; no rready until accepted.
REQ-030 rid = 1 during an m0 burst, or rlast on beat 2 of len 3 -> data forwarded, rd_err = 1 and stays 1; FSM returns to IDLE on rlast.
REQ-031 areset pulsed during the 2nd beat of the DATA phase -> outputs 0 in the same cycle; after release an m1 request is granted first and completes normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI3 read arbiter: one burst outstanding, alternating grant on ties.
// Flags rid/rlast/beat-count protocol violations on a sticky error bit.
module axi_rd_arbiter #(
  parameter logic [3:0] ID0 = 4'd0,
  parameter logic [3:0] ID1 = 4'd1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  output logic        m0_arready,
  output logic        m0_rvalid,
  output logic        m0_rlast,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  output logic        m1_arready,
  output logic        m1_rvalid,
  output logic        m1_rlast,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  output logic        rready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rd_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e      state_q, state_d;
  logic        grant_q, last_grant_q, err_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q, beat_q;
  logic [2:0]  size_q;
  logic        any_req, grant_sel, do_grant, beat, beat_err;
  logic [3:0]  gid;

  assign any_req   = m0_arvalid | m1_arvalid;
  // last_grant_q holds the index of the most recent winner; a tie goes to the other one
  assign grant_sel = (m0_arvalid && m1_arvalid) ? ~last_grant_q : m1_arvalid;
  assign do_grant  = (state_q == IDLE) && any_req && !areset;
  assign beat      = (state_q == DATA) && rvalid;
  assign gid       = grant_q ? ID1 : ID0;
  assign beat_err  = beat && ((rid != gid) ||
                              (rlast && (beat_q != len_q)) ||
                              (!rlast && (beat_q == len_q)));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ADDR;
      ADDR:    if (arready) state_d = DATA;
      DATA:    if (rvalid && rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m0_arready = do_grant && !grant_sel;
    m1_arready = do_grant && grant_sel;
    arvalid    = (state_q == ADDR);
    rready     = (state_q == DATA);
    m0_rvalid  = beat && !grant_q;
    m1_rvalid  = beat && grant_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      if (do_grant) begin
        grant_q      <= grant_sel;
        last_grant_q <= grant_sel;
        addr_q       <= grant_sel ? m1_araddr : m0_araddr;
        len_q        <= grant_sel ? m1_arlen  : m0_arlen;
        size_q       <= grant_sel ? m1_arsize : m0_arsize;
        beat_q       <= '0;
      end else if (beat) begin
        beat_q <= beat_q + 8'd1;
      end
      if (beat_err) err_q <= 1'b1;
    end
  end

  assign arid     = gid;
  assign araddr   = addr_q;
  assign arlen    = len_q;
  assign arsize   = size_q;
  assign arburst  = 2'b01;
  assign arlock   = 2'b00;
  assign arcache  = 4'b0000;
  assign arprot   = 3'b000;
  assign rd_err   = err_q;

  assign m0_rdata = rdata;
  assign m0_rresp = rresp;
  assign m0_rlast = rlast;
  assign m1_rdata = rdata;
  assign m1_rresp = rresp;
  assign m1_rlast = rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: AR and R scoreboards fed as stimulus is driven.
module tb_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        m0_arvalid = 0, m1_arvalid = 0;
  logic [31:0] m0_araddr = '0, m1_araddr = '0;
  logic [7:0]  m0_arlen = '0, m1_arlen = '0;
  logic [2:0]  m0_arsize = '0, m1_arsize = '0;
  logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, rready, rd_err;
  logic        arready = 0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 0, rvalid = 0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size;} ar_t;
  typedef struct packed {logic w; logic [31:0] data; logic [1:0] resp; logic last;} r_t;
  ar_t ar_q[$];
  r_t  r_q[$];
  logic lg = 1'b1;
  logic err_exp = 1'b0;

  axi_rd_arbiter dut (
    .aclk(aclk), .areset(areset),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rd_err(rd_err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    m0_arvalid = 0; m1_arvalid = 0; arready = 0; rvalid = 0; rlast = 0;
    #1;
    checks++;
    if ({arvalid, rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, rd_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {arvalid, rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, rd_err});
    end
    checks++;
    if ({araddr, arlen, arsize, arburst, arlock, arcache, arprot} !== {32'h0, 8'h0, 3'h0, 2'b01, 2'b00, 4'h0, 3'h0}) begin
      errors++;
      $display("FAIL reset_fields: araddr %h arlen %h arsize %h arburst %b expected 0,0,0,01",
               araddr, arlen, arsize, arburst);
    end
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    lg = 1'b1;
    err_exp = 1'b0;
    ar_q.delete();
    r_q.delete();
  endtask

  task automatic grant_phase(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [7:0] l0, input logic [7:0] l1, input logic [2:0] s0,
                             input logic [2:0] s1, input bit no_wait);
    logic w;
    ar_t  e;
    w  = (v0 && v1) ? ~lg : v1;
    lg = w;
    if (!no_wait) @(negedge aclk);
    m0_arvalid = v0; m1_arvalid = v1;
    m0_araddr = a0; m1_araddr = a1; m0_arlen = l0; m1_arlen = l1; m0_arsize = s0; m1_arsize = s1;
    #1;
    checks++;
    if ({m0_arready, m1_arready} !== (w ? 2'b01 : 2'b10)) begin
      errors++;
      $display("FAIL grant: arready m0/m1 %b expected %b", {m0_arready, m1_arready}, (w ? 2'b01 : 2'b10));
    end
    checks++;
    if (arvalid !== 1'b0) begin
      errors++;
      $display("FAIL arvalid_at_grant: got %b expected 0", arvalid);
    end
    e.id = w ? 4'd1 : 4'd0;
    e.addr = w ? a1 : a0;
    e.len = w ? l1 : l0;
    e.size = w ? s1 : s0;
    ar_q.push_back(e);
    @(negedge aclk);
    m0_arvalid = 0; m1_arvalid = 0;
    #1;
    checks++;
    if ({m0_arready, m1_arready} !== 2'b00) begin
      errors++;
      $display("FAIL arready_in_addr: got %b expected 00", {m0_arready, m1_arready});
    end
  endtask

  task automatic addr_phase(input int wait_cycles, input bit stray);
    ar_t e;
    if (ar_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL ar_scoreboard: empty expected queue, got 0 entries expected 1");
      return;
    end
    e = ar_q[0];
    for (int i = 0; i <= wait_cycles; i++) begin
      arready = (i == wait_cycles);
      rvalid = stray; rlast = stray; rid = 4'hF;
      #1;
      checks++;
      if ({arvalid, arid, araddr, arlen, arsize} !== {1'b1, e.id, e.addr, e.len, e.size}) begin
        errors++;
        $display("FAIL ar_channel cyc%0d: arvalid %b arid %h araddr %h arlen %h arsize %h expected 1 %h %h %h %h",
                 i, arvalid, arid, araddr, arlen, arsize, e.id, e.addr, e.len, e.size);
      end
      checks++;
      if ({rready, m0_rvalid, m1_rvalid, rd_err} !== {3'b000, err_exp}) begin
        errors++;
        $display("FAIL r_in_addr cyc%0d: rready/m0_rvalid/m1_rvalid/rd_err %b expected 000%b",
                 i, {rready, m0_rvalid, m1_rvalid, rd_err}, err_exp);
      end
      @(negedge aclk);
    end
    arready = 0; rvalid = 0; rlast = 0;
    void'(ar_q.pop_front());
  endtask

  task automatic data_phase(input logic w, input int len, input int nbeats, input int last_at,
                            input logic [3:0] rid_v);
    r_t e, got;
    logic [3:0] gid;
    gid = w ? 4'd1 : 4'd0;
    for (int b = 0; b < nbeats; b++) begin
      rvalid = 1; rdata = $urandom; rresp = 2'(b); rlast = (b == last_at); rid = rid_v;
      e = '{w: w, data: rdata, resp: rresp, last: rlast};
      r_q.push_back(e);
      if ((rid_v != gid) || (rlast && b != len) || (!rlast && b == len)) err_exp = 1'b1;
      #1;
      checks++;
      if ({rready, (w ? m0_rvalid : m1_rvalid)} !== 2'b10) begin
        errors++;
        $display("FAIL data_gate beat%0d: rready/other_rvalid %b expected 10", b, {rready, (w ? m0_rvalid : m1_rvalid)});
      end
      checks++;
      if ((w ? m1_rvalid : m0_rvalid) === 1'b1) begin
        got = w ? '{w: 1'b1, data: m1_rdata, resp: m1_rresp, last: m1_rlast}
                : '{w: 1'b0, data: m0_rdata, resp: m0_rresp, last: m0_rlast};
        e = r_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL r_beat%0d: got %h expected %h", b, got, e);
        end
      end else begin
        errors++;
        $display("FAIL r_fwd beat%0d: granted rvalid %b expected 1", b, (w ? m1_rvalid : m0_rvalid));
      end
      @(negedge aclk);
      checks++;
      if (rd_err !== err_exp) begin
        errors++;
        $display("FAIL rd_err beat%0d: got %b expected %b", b, rd_err, err_exp);
      end
    end
    rvalid = 0; rlast = 0;
    #1;
    checks++;
    if ({rready, arvalid, r_q.size() == 0} !== 3'b001) begin
      errors++;
      $display("FAIL burst_end: rready/arvalid/r_q_empty %b expected 001", {rready, arvalid, r_q.size() == 0});
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single();
    grant_phase(1, 0, 32'h1C00_0000, 32'h0, 8'd3, 8'd0, 3'd2, 3'd0, 0);
    addr_phase(0, 0);
    data_phase(0, 3, 4, 3, 4'd0);
  endtask

  task automatic test_ar_stall();
    grant_phase(0, 1, 32'h0, 32'h8000_1234, 8'd0, 8'd1, 3'd0, 3'd2, 0);
    addr_phase(5, 0);
    data_phase(1, 1, 2, 1, 4'd1);
  endtask

  task automatic test_tie();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      grant_phase(1, 1, 32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k), 8'd1, 8'd2, 3'd2, 3'd1, 0);
      addr_phase(k, 0);
      data_phase(lg, lg ? 2 : 1, lg ? 3 : 2, lg ? 2 : 1, lg ? 4'd1 : 4'd0);
    end
  endtask

  task automatic test_back_to_back();
    grant_phase(0, 1, 32'h0, 32'h3000_0040, 8'd0, 8'd0, 3'd0, 3'd2, 0);
    addr_phase(1, 0);
    data_phase(1, 0, 1, 0, 4'd1);
    grant_phase(1, 0, 32'h3000_0080, 32'h0, 8'd2, 8'd0, 3'd2, 3'd0, 1);
    addr_phase(0, 0);
    data_phase(0, 2, 3, 2, 4'd0);
  endtask

  task automatic test_stray();
    @(negedge aclk);
    rvalid = 1; rlast = 1; rid = 4'd7;
    #1;
    checks++;
    if ({rready, m0_rvalid, m1_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL stray_idle: rready/m0_rvalid/m1_rvalid %b expected 000", {rready, m0_rvalid, m1_rvalid});
    end
    @(negedge aclk);
    rvalid = 0; rlast = 0;
    grant_phase(1, 0, 32'h4000_0000, 32'h0, 8'd1, 8'd0, 3'd2, 3'd0, 0);
    addr_phase(2, 1);
    data_phase(0, 1, 2, 1, 4'd0);
    checks++;
    if (rd_err !== 1'b0) begin
      errors++;
      $display("FAIL stray_err: rd_err %b expected 0", rd_err);
    end
  endtask

  task automatic test_errors();
    grant_phase(1, 0, 32'h5000_0000, 32'h0, 8'd3, 8'd0, 3'd2, 3'd0, 0);
    addr_phase(0, 0);
    data_phase(0, 3, 4, 3, 4'd1);
    repeat (3) @(negedge aclk);
    checks++;
    if (rd_err !== 1'b1) begin
      errors++;
      $display("FAIL rd_err_sticky: got %b expected 1", rd_err);
    end
    do_reset();
    grant_phase(1, 0, 32'h5000_0100, 32'h0, 8'd3, 8'd0, 3'd2, 3'd0, 0);
    addr_phase(0, 0);
    data_phase(0, 3, 3, 2, 4'd0);
    do_reset();
    grant_phase(0, 1, 32'h0, 32'h5000_0200, 8'd0, 8'd1, 3'd0, 3'd2, 0);
    addr_phase(0, 0);
    data_phase(1, 1, 3, 2, 4'd1);
  endtask

  task automatic test_mid_reset();
    do_reset();
    grant_phase(1, 0, 32'h6000_0000, 32'h0, 8'd3, 8'd0, 3'd2, 3'd0, 0);
    addr_phase(0, 0);
    rvalid = 1; rlast = 0; rid = 4'd0; rdata = 32'hA5A5_0000;
    @(negedge aclk);
    rdata = 32'hA5A5_0001; m0_arvalid = 1;
    #1;
    checks++;
    if (m0_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_beat2: m0_rvalid %b expected 1", m0_rvalid);
    end
    areset = 1'b1;
    #1;
    checks++;
    if ({arvalid, rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, rd_err} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected 0000000",
               {arvalid, rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, rd_err});
    end
    @(negedge aclk);
    rvalid = 0; m0_arvalid = 0; areset = 1'b0;
    lg = 1'b1; err_exp = 1'b0; ar_q.delete(); r_q.delete();
    grant_phase(0, 1, 32'h0, 32'h7000_0010, 8'd0, 8'd2, 3'd0, 3'd2, 0);
    addr_phase(1, 0);
    data_phase(1, 2, 3, 2, 4'd1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_ar_stall();
    test_tie();
    test_back_to_back();
    test_stray();
    test_errors();
    test_mid_reset();
    repeat (2) @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
